// File: rtl/fir_coef_loader.sv
// Coefficient loader: fills a shadow bank from a valid/ready stream and commits it atomically
// to the active tap-weight bank in a cycle with no sample enable. Optional: FIR_COEF_SYMMETRIC_EN.
module fir_coef_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_TAPS   = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_en,
  input  logic                           i_coef_valid,
  output logic                           o_coef_ready,
  input  logic [DATA_WIDTH-1:0]          iv_coef,
  input  logic                           i_coef_last,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  output logic                           o_pending,
  output logic                           o_commit,
  output logic                           o_err
);

  localparam int unsigned IDX_W = $clog2(NUM_TAPS);
`ifdef FIR_COEF_SYMMETRIC_EN
  localparam int unsigned N_BEATS = (NUM_TAPS + 1) / 2;
`else
  localparam int unsigned N_BEATS = NUM_TAPS;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEATS - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  state_e                                  state_q, state_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]     shadow_q, shadow_d;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]     active_q, active_d;
  logic                                    ready_q, ready_d;
  logic                                    pending_q, pending_d;
  logic                                    commit_q, commit_d;
  logic                                    err_q, err_d;
  logic                                    at_last;

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_LOAD;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      ready_q   <= 1'b1;
      pending_q <= 1'b0;
      commit_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
      commit_q  <= commit_d;
      err_q     <= err_d;
    end
  end

  // Next-state: framing check on each accepted beat, commit gated by the sample enable
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    at_last  = (idx_q == LAST_IDX);

    case (state_q)
      ST_LOAD: begin
        if (i_coef_valid) begin
          if (i_coef_last != at_last) begin
            // Early or missing last: drop the beat and restart framing
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            shadow_d[idx_q] = iv_coef;
`ifdef FIR_COEF_SYMMETRIC_EN
            shadow_d[IDX_W'(NUM_TAPS - 1) - idx_q] = iv_coef;
`endif
            if (at_last) begin
              idx_d   = '0;
              state_d = ST_PEND;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      ST_PEND: begin
        if (!i_en) begin
          active_d = shadow_q;
          commit_d = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign ready_d   = (state_d == ST_LOAD);
  assign pending_d = (state_d == ST_PEND);

  assign o_coef_ready = ready_q;
  assign o_pending    = pending_q;
  assign o_commit     = commit_q;
  assign o_err        = err_q;
  assign ov_weights   = active_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader (DATA_WIDTH=8, NUM_TAPS=4); commits are scored
// against a queue of expected weight sets. Symmetric scenario runs when FIR_COEF_SYMMETRIC_EN is defined.
module tb_fir_coef_loader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_coef_valid;
  logic        o_coef_ready;
  logic [7:0]  iv_coef;
  logic        i_coef_last;
  logic [31:0] ov_weights;
  logic        o_pending;
  logic        o_commit;
  logic        o_err;

  int          checks = 0;
  int          errors = 0;
  int          commit_cnt = 0;
  logic [31:0] exp_q[$];

  fir_coef_loader #(.DATA_WIDTH(8), .NUM_TAPS(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_coef_valid(i_coef_valid),
    .o_coef_ready(o_coef_ready),
    .iv_coef     (iv_coef),
    .i_coef_last (i_coef_last),
    .ov_weights  (ov_weights),
    .o_pending   (o_pending),
    .o_commit    (o_commit),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Scoreboard: every commit pulse must match the oldest expected weight set
  always @(negedge i_clk) begin
    if (o_commit) begin
      commit_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_commit: unexpected commit, weights=%08h, expected no commit", ov_weights);
      end else begin
        logic [31:0] exp_w;
        exp_w = exp_q.pop_front();
        if (ov_weights !== exp_w) begin
          errors++;
          $display("FAIL sb_weights: got %08h expected %08h", ov_weights, exp_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic last);
    i_coef_valid = 1'b1;
    iv_coef      = c;
    i_coef_last  = last;
    tick();
    i_coef_valid = 1'b0;
    i_coef_last  = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_en = 1'b0; i_coef_valid = 1'b0; iv_coef = '0; i_coef_last = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    checks++; if (ov_weights !== 32'h0) begin errors++; $display("FAIL rst_weights: got %08h expected 00000000", ov_weights); end
    checks++; if (o_coef_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", o_coef_ready); end
    checks++; if (o_pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b expected 0", o_pending); end
    checks++; if (o_commit !== 1'b0) begin errors++; $display("FAIL rst_commit: got %b expected 0", o_commit); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", o_err); end
  endtask

  task automatic test_load();
    int c0;
    c0 = commit_cnt;
    i_en = 1'b0;
    exp_q.push_back(32'h40302010);
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b1);
    checks++; if (o_pending !== 1'b1) begin errors++; $display("FAIL load_pending: got %b expected 1", o_pending); end
    checks++; if (o_coef_ready !== 1'b0) begin errors++; $display("FAIL load_ready_low: got %b expected 0", o_coef_ready); end
    checks++; if (ov_weights !== 32'h0) begin errors++; $display("FAIL load_early_weights: got %08h expected 00000000", ov_weights); end
    tick();
    checks++; if (o_commit !== 1'b1) begin errors++; $display("FAIL load_commit: got %b expected 1", o_commit); end
    checks++; if (ov_weights !== 32'h40302010) begin errors++; $display("FAIL load_weights: got %08h expected 40302010", ov_weights); end
    checks++; if (o_coef_ready !== 1'b1) begin errors++; $display("FAIL load_ready_back: got %b expected 1", o_coef_ready); end
    tick();
    checks++; if (o_commit !== 1'b0) begin errors++; $display("FAIL load_commit_pulse: got %b expected 0", o_commit); end
    checks++; if (commit_cnt - c0 != 1) begin errors++; $display("FAIL load_commit_count: got %0d expected 1", commit_cnt - c0); end
  endtask

  task automatic test_commit_blocked();
    int e0;
    e0 = 0;
    i_en = 1'b1;
    exp_q.push_back(32'hD4C3B2A1);
    send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b0); send(8'hD4, 1'b1);
    // A beat offered in PEND must be ignored (would otherwise be an early-last error)
    i_coef_valid = 1'b1; iv_coef = 8'hEE; i_coef_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e0 += int'(o_err);
      checks++;
      if (o_pending !== 1'b1 || o_coef_ready !== 1'b0 || o_commit !== 1'b0 || ov_weights !== 32'h40302010) begin
        errors++;
        $display("FAIL blocked_hold[%0d]: pend=%b ready=%b commit=%b w=%08h expected 1 0 0 40302010",
                 i, o_pending, o_coef_ready, o_commit, ov_weights);
      end
      tick();
    end
    i_coef_valid = 1'b0; i_coef_last = 1'b0;
    i_en = 1'b0;
    tick();
    checks++; if (o_commit !== 1'b1 || ov_weights !== 32'hD4C3B2A1) begin errors++;
      $display("FAIL blocked_commit: commit=%b w=%08h expected 1 D4C3B2A1", o_commit, ov_weights); end
    checks++; if (e0 != 0 || o_err !== 1'b0) begin errors++; $display("FAIL blocked_ignore: err seen %0d expected 0", e0); end
    tick();
  endtask

  task automatic test_early_last();
    int c0;
    c0 = commit_cnt;
    send(8'h11, 1'b0); send(8'h22, 1'b1);
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL early_err: got %b expected 1", o_err); end
    checks++; if (o_pending !== 1'b0 || o_coef_ready !== 1'b1) begin errors++;
      $display("FAIL early_state: pend=%b ready=%b expected 0 1", o_pending, o_coef_ready); end
    tick();
    checks++; if (o_err !== 1'b0 || commit_cnt != c0) begin errors++;
      $display("FAIL early_after: err=%b commits=%0d expected 0 %0d", o_err, commit_cnt, c0); end
    exp_q.push_back(32'h04030201);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
    tick();
    checks++; if (o_commit !== 1'b1 || ov_weights !== 32'h04030201) begin errors++;
      $display("FAIL early_recover: commit=%b w=%08h expected 1 04030201", o_commit, ov_weights); end
    tick();
  endtask

  task automatic test_missing_last();
    int c0;
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL miss_no_err_yet: got %b expected 0", o_err); end
    send(8'h88, 1'b0);
    checks++; if (o_err !== 1'b1 || o_pending !== 1'b0) begin errors++;
      $display("FAIL miss_err: err=%b pend=%b expected 1 0", o_err, o_pending); end
    tick(); tick();
    checks++; if (ov_weights !== 32'h04030201) begin errors++; $display("FAIL miss_weights: got %08h expected 04030201", ov_weights); end
    // Reset while a set is pending: weights clear, no commit
    c0 = commit_cnt;
    i_en = 1'b1;
    send(8'h99, 1'b0); send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
    checks++; if (o_pending !== 1'b1) begin errors++; $display("FAIL rstpend_pending: got %b expected 1", o_pending); end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; i_en = 1'b0;
    checks++; if (ov_weights !== 32'h0 || o_pending !== 1'b0 || o_coef_ready !== 1'b1) begin errors++;
      $display("FAIL rstpend_state: w=%08h pend=%b ready=%b expected 00000000 0 1", ov_weights, o_pending, o_coef_ready); end
    tick(); tick(); tick();
    checks++; if (commit_cnt != c0 || ov_weights !== 32'h0) begin errors++;
      $display("FAIL rstpend_nocommit: commits=%0d w=%08h expected %0d 00000000", commit_cnt, ov_weights, c0); end
  endtask

  task automatic test_symmetric();
    i_en = 1'b0;
    exp_q.push_back(32'h7F80807F);
    send(8'h7F, 1'b0); send(8'h80, 1'b1);
    checks++; if (o_pending !== 1'b1) begin errors++; $display("FAIL sym_pending: got %b expected 1", o_pending); end
    tick();
    checks++; if (o_commit !== 1'b1 || ov_weights !== 32'h7F80807F) begin errors++;
      $display("FAIL sym_weights: commit=%b w=%08h expected 1 7F80807F", o_commit, ov_weights); end
    send(8'h01, 1'b1);
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL sym_early: got %b expected 1", o_err); end
    tick();
  endtask

  initial begin
    test_reset();
`ifdef FIR_COEF_SYMMETRIC_EN
    test_symmetric();
`else
    test_load();
    test_commit_blocked();
    test_early_last();
    test_missing_last();
`endif
    tick(); tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d expected commits missing, expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
